serial_shift_tx: RTL

- Parallel-in, serial-out shift transmitter. It is the sending end of a serial delay/shift chain.
- Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out one bit per clk, with frame and last-bit strobes.
- Inserts a programmable idle gap between frames.
- Sits upstream of the registered shift-chain receivers in the datapath and drives their serial input directly from a flop.

---
 rtl/serial_shift_tx.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_shift_tx.sv
// Parallel-in, serial-out shift transmitter: accepts a word over valid/ready and
// emits it one bit per clk from a flop, with frame/last strobes and an idle gap.
module serial_shift_tx #(
    parameter int DATA_W    = 8,
    parameter int GAP_CYC   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              sout,
    output logic              sout_frame,
    output logic              sout_last,
    output logic              busy
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DATA_W - 1);
    localparam logic [3:0]        GAP_LOAD = 4'(GAP_CYC - 1);
    localparam bit                GAP_EN   = (GAP_CYC > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        gcnt, gcnt_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              sout_q, sout_nxt;
    logic              xfer;

    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    // Ready depends on state only, so upstream can never form a comb loop through us.
    always_comb begin
        din_ready = (state == IDLE) ||
                    ((state == SHIFT) && (cnt == '0) && !GAP_EN);
        xfer      = din_valid && din_ready;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gcnt_nxt  = gcnt;
        shreg_nxt = shreg;
        sout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = CNT_LOAD;
                    sout_nxt  = head_bit(din);
                    shreg_nxt = advance(din);
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    cnt_nxt   = cnt - CNT_W'(1);
                    sout_nxt  = head_bit(shreg);
                    shreg_nxt = advance(shreg);
                end else if (xfer) begin
                    // Zero-gap back-to-back: reload without leaving SHIFT.
                    cnt_nxt   = CNT_LOAD;
                    sout_nxt  = head_bit(din);
                    shreg_nxt = advance(din);
                end else if (GAP_EN) begin
                    state_nxt = GAP;
                    gcnt_nxt  = GAP_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (gcnt == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gcnt_nxt = gcnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            gcnt   <= 4'd0;
            shreg  <= '0;
            sout_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            gcnt   <= gcnt_nxt;
            shreg  <= shreg_nxt;
            sout_q <= sout_nxt;
        end
    end

    assign sout       = sout_q;
    assign sout_frame = (state == SHIFT);
    assign sout_last  = (state == SHIFT) && (cnt == '0);
    assign busy       = (state != IDLE);

endmodule
